// File: rtl/hps_irq_pkg.sv
// Shared definitions for the pushbutton event counter: debounce FSM states,
// BCD digit format and the single-digit increment helper.
package hps_irq_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } deb_state_e;

    localparam int                DIGIT_W   = 4;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

    typedef struct packed {
        logic [DIGIT_W-1:0] tens;
        logic [DIGIT_W-1:0] ones;
    } bcd2_t;

    // Returns {carry, next_digit}; any value at or above 9 wraps to 0 so an
    // out-of-range digit can never persist.
    function automatic logic [DIGIT_W:0] digit_inc(input logic [DIGIT_W-1:0] d);
        logic [DIGIT_W:0] r;
        if (d >= DIGIT_MAX) begin
            r = {1'b1, {DIGIT_W{1'b0}}};
        end else begin
            r = {1'b0, d + 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer and four-state debouncer for an active-low pushbutton;
// emits one press_pulse per accepted press, nothing on release.
module key_debounce
    import hps_irq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press_pulse
);

    localparam int              CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             key_s;
    deb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_pulse_q, press_pulse_d;

    always_comb begin
        sync1_d = key_n;
        sync2_d = sync1_q;
        key_s   = sync2_q;
    end

    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        state_d       = state_q;
        cnt_d         = cnt_q;
        press_pulse_d = 1'b0;
        case (state_q)
            RELEASED: begin
                if (!key_s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (key_s) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d       = PRESSED;
                    cnt_d         = '0;
                    press_pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (key_s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (!key_s) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            state_q       <= RELEASED;
            cnt_q         <= '0;
            press_pulse_q <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            press_pulse_q <= press_pulse_d;
        end
    end

    assign press_pulse = press_pulse_q;

endmodule

// File: rtl/key_event_counter.sv
// Pushbutton event counter: debounced presses drive a two-digit BCD count with
// sticky overflow and a level interrupt acknowledged by the HPS.
module key_event_counter
    import hps_irq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               key_n,
    input  logic               count_clr,
    input  logic               irq_ack,
    output logic [DIGIT_W-1:0] ones_digit,
    output logic [DIGIT_W-1:0] tens_digit,
    output logic               press_pulse,
    output logic               irq,
    output logic               overflow
);

    logic             press;
    bcd2_t            count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             irq_q, irq_d;
    logic [DIGIT_W:0] ones_inc;
    logic [DIGIT_W:0] tens_inc;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk        (clk),
        .reset      (reset),
        .key_n      (key_n),
        .press_pulse(press)
    );

    always_comb begin
        count_d    = count_q;
        overflow_d = overflow_q;
        ones_inc   = digit_inc(count_q.ones);
        tens_inc   = digit_inc(count_q.tens);
        // Clear outranks a coincident increment; the interrupt is still raised.
        if (count_clr) begin
            count_d    = '0;
            overflow_d = 1'b0;
        end else if (press) begin
            count_d.ones = ones_inc[DIGIT_W-1:0];
            if (ones_inc[DIGIT_W]) begin
                count_d.tens = tens_inc[DIGIT_W-1:0];
                if (tens_inc[DIGIT_W]) begin
                    overflow_d = 1'b1;
                end
            end
        end
        irq_d = press | (irq_q & ~irq_ack);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            count_q    <= count_d;
            overflow_q <= overflow_d;
            irq_q      <= irq_d;
        end
    end

    assign ones_digit  = count_q.ones;
    assign tens_digit  = count_q.tens;
    assign press_pulse = press;
    assign irq         = irq_q;
    assign overflow    = overflow_q;

endmodule
